// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader: shifts per-pad GPIO control words MSB-first into the pad chain, then strobes load.
// Optional macro SERIAL_RESET_EN adds a chain reset phase and the serial_resetn port.
module mprj_io_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV = 4,
  localparam int IW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1,
  localparam int DW = $clog2(CLK_DIV + 1),
  localparam int BW = CFG_BITS > 1 ? $clog2(CFG_BITS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IW-1:0]       cfg_idx,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load
`ifdef SERIAL_RESET_EN
  ,
  output logic                serial_resetn
`endif
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd2, CAPT = 3'd3, SHIFT_LO = 3'd4,
                         SHIFT_HI = 3'd5, LOAD = 3'd6, DONE = 3'd7;
`ifdef SERIAL_RESET_EN
  localparam logic [2:0] RST = 3'd1, FIRST = RST;
`else
  localparam logic [2:0] FIRST = ADDR;
`endif
  logic [2:0] state, nxt;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt;
  logic [CFG_BITS-1:0] sr;
  logic tick;
  assign tick = div == '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? FIRST : IDLE;
`ifdef SERIAL_RESET_EN
      RST:      nxt = tick ? ADDR : RST;
`endif
      ADDR:     nxt = CAPT;
      CAPT:     nxt = SHIFT_LO;
      SHIFT_LO: nxt = tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: nxt = !tick ? SHIFT_HI : bit_cnt != '0 ? SHIFT_LO : cfg_idx != '0 ? ADDR : LOAD;
      LOAD:     nxt = tick ? DONE : LOAD;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // Outputs are registered decodes of the current state, so they trail it by one cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
      cfg_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      serial_clock <= 1'b0;
      serial_data_out <= 1'b0;
      serial_load <= 1'b0;
`ifdef SERIAL_RESET_EN
      serial_resetn <= 1'b1;
`endif
    end else begin
      state <= nxt;
      div <= nxt != state ? DW'(CLK_DIV - 1) : tick ? div : div - DW'(1);
      if (state == IDLE && start)
        cfg_idx <= IW'(NUM_PADS - 1);
      else if (state == SHIFT_HI && nxt == ADDR)
        cfg_idx <= cfg_idx - IW'(1);
      if (state == CAPT) begin
        sr <= cfg_data;
        bit_cnt <= BW'(CFG_BITS - 1);
      end else if (state == SHIFT_HI && tick) begin
        sr <= sr << 1;
        bit_cnt <= bit_cnt != '0 ? bit_cnt - BW'(1) : bit_cnt;
      end
      busy <= state != IDLE && state != DONE;
      done <= state == DONE;
      serial_clock <= state == SHIFT_HI;
      serial_load <= state == LOAD;
      serial_data_out <= state == SHIFT_LO ? sr[CFG_BITS-1] : state == LOAD ? 1'b0 : serial_data_out;
`ifdef SERIAL_RESET_EN
      serial_resetn <= state != RST;
`endif
    end
  end
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb_mprj_io_cfg_loader: table, random and corner-case transfers checked against a chain model.
module tb_mprj_io_cfg_loader;
  typedef struct {
    logic [12:0] p1;
    logic [12:0] p0;
    logic [25:0] exp_chain;
  } vec_t;
`ifdef SERIAL_RESET_EN
  localparam int RSTC = 1;
`else
  localparam int RSTC = 0;
`endif
  localparam int BUSY0 = 2 * (2 + 2 * 2 * 13) + 2 + 2 * RSTC;
  localparam int BUSY1 = 1 * (2 + 2 * 1 * 13) + 1 + 1 * RSTC;
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, s_clk0, s_dat0, s_load0, s_rstn0;
  logic busy1, done1, s_clk1, s_dat1, s_load1, s_rstn1;
  logic [0:0] idx0, idx1;
  logic [12:0] data0, data1;
  logic [12:0] mem [2];
  logic [25:0] chain0 = '0, latched0 = '0;
  logic [12:0] chain1 = '0;
  int vectors = 0, miscompares = 0;
  int busy_c = 0, done_c = 0, load_c = 0, loadp_c = 0, ovl_c = 0, unst_c = 0, rstl_c = 0, rises0 = 0;
  int busy1_c = 0, done1_c = 0, hi1_c = 0, rises1 = 0;
  int db, dd, dl, dlp, dov, dun, drl, dr;
  logic pb = 1'b0, pl = 1'b0, pd = 1'b0, first_rstn = 1'b1;
  vec_t tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) data0 <= mem[idx0];
  assign data1 = 13'h1FFF;

  mprj_io_cfg_loader #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(2)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start0), .busy(busy0), .done(done0),
    .cfg_idx(idx0), .cfg_data(data0), .serial_clock(s_clk0), .serial_data_out(s_dat0),
    .serial_load(s_load0)
`ifdef SERIAL_RESET_EN
    , .serial_resetn(s_rstn0)
`endif
  );
  mprj_io_cfg_loader #(.NUM_PADS(1), .CFG_BITS(13), .CLK_DIV(1)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start1), .busy(busy1), .done(done1),
    .cfg_idx(idx1), .cfg_data(data1), .serial_clock(s_clk1), .serial_data_out(s_dat1),
    .serial_load(s_load1)
`ifdef SERIAL_RESET_EN
    , .serial_resetn(s_rstn1)
`endif
  );
`ifndef SERIAL_RESET_EN
  assign s_rstn0 = 1'b1;
  assign s_rstn1 = 1'b1;
`endif

  // Pad chain model: shift on rising serial_clock, latch on rising serial_load.
  always @(posedge s_clk0 or negedge s_rstn0) begin
    if (!s_rstn0) chain0 <= '0;
    else begin
      chain0 <= {chain0[24:0], s_dat0};
      rises0 <= rises0 + 1;
    end
  end
  always @(posedge s_load0) latched0 <= chain0;
  always @(posedge s_clk1) begin
    chain1 <= {chain1[11:0], s_dat1};
    rises1 <= rises1 + 1;
  end

  always @(negedge clk) begin
    busy_c <= busy_c + int'(busy0);
    done_c <= done_c + int'(done0);
    load_c <= load_c + int'(s_load0);
    loadp_c <= loadp_c + int'(s_load0 && !pl);
    ovl_c <= ovl_c + int'(s_clk0 && s_load0) + int'(s_clk1 && s_load1);
    unst_c <= unst_c + int'(s_clk0 && s_dat0 != pd);
    rstl_c <= rstl_c + int'(!s_rstn0);
    if (busy0 && !pb) first_rstn <= s_rstn0;
    pb <= busy0;
    pl <= s_load0;
    pd <= s_dat0;
    busy1_c <= busy1_c + int'(busy1);
    done1_c <= done1_c + int'(done1);
    hi1_c <= hi1_c + int'(s_clk1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [12:0] p1, input logic [12:0] p0, input int mid);
    int b, d, l, lp, o, u, rl, r;
    mem[1] = p1;
    mem[0] = p0;
    @(negedge clk);
    b = busy_c; d = done_c; l = load_c; lp = loadp_c; o = ovl_c; u = unst_c; rl = rstl_c; r = rises0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_lag", int'(busy0), 0);
    @(negedge clk);
    chk("busy_rise", int'(busy0), 1);
    if (mid > 0) begin
      repeat (mid) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    for (int i = 0; i < 3000 && done_c == d; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    db = busy_c - b; dd = done_c - d; dl = load_c - l; dlp = loadp_c - lp;
    dov = ovl_c - o; dun = unst_c - u; drl = rstl_c - rl; dr = rises0 - r;
  endtask

  task automatic check_xfer(input string nm, input logic [25:0] exp_chain);
    chk({nm, "_busy_cycles"}, db, BUSY0);
    chk({nm, "_clk_rises"}, dr, 26);
    chk({nm, "_load_cycles"}, dl, 2);
    chk({nm, "_load_pulses"}, dlp, 1);
    chk({nm, "_done_cycles"}, dd, 1);
    chk({nm, "_clk_load_overlap"}, dov, 0);
    chk({nm, "_data_unstable"}, dun, 0);
    chk({nm, "_chain"}, int'(latched0), int'(exp_chain));
`ifdef SERIAL_RESET_EN
    chk({nm, "_resetn_cycles"}, drl, 2);
    chk({nm, "_resetn_first"}, int'(first_rstn), 0);
`else
    chk({nm, "_resetn_cycles"}, drl, 0);
`endif
  endtask

  initial begin
    logic [12:0] pads [2];
    logic [25:0] expv, old;
    int bad, r, lp, b, d, h;
    tbl[0] = '{13'h1A5B, 13'h0C3F, 26'h34B6C3F};
    tbl[1] = '{13'h1FFF, 13'h0000, 26'h3FFE000};
    tbl[2] = '{13'h0000, 13'h1FFF, 26'h0001FFF};
    tbl[3] = '{13'h1555, 13'h0AAA, 26'h2AAAAAA};
    mem[0] = '0;
    mem[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs0", int'({busy0, done0, s_clk0, s_dat0, s_load0, s_rstn0, idx0}), 'b0000010);
    chk("rst_outputs1", int'({busy1, done1, s_clk1, s_dat1, s_load1, s_rstn1, idx1}), 'b0000010);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad += int'({busy0, done0, s_clk0, s_dat0, s_load0, s_rstn0, idx0} != 7'b0000010);
    end
    chk("idle_hold", bad, 0);
    for (int i = 0; i < 4; i++) begin
      xfer(tbl[i].p1, tbl[i].p0, 0);
      check_xfer($sformatf("tbl%0d", i), tbl[i].exp_chain);
    end
    for (int i = 0; i < 6; i++) begin
      pads[1] = 13'($urandom);
      pads[0] = 13'($urandom);
      expv = '0;
      for (int p = 1; p >= 0; p--) expv = (expv << 13) | 26'(pads[p]);
      xfer(pads[1], pads[0], 0);
      check_xfer($sformatf("rnd%0d", i), expv);
    end
    xfer(13'h0F0F, 13'h10F0, 30);
    check_xfer("start_busy", 26'h1E1F0F0);
    old = latched0;
    mem[1] = 13'h0123;
    mem[0] = 13'h1ABC;
    r = rises0;
    lp = loadp_c;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 500 && rises0 - r < 10; i++) @(negedge clk);
    chk("rst_mid_rises", rises0 - r, 10);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({busy0, s_clk0, s_load0, s_dat0}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_load", loadp_c - lp, 0);
    chk("rst_mid_keep", int'(latched0), int'(old));
    xfer(13'h0123, 13'h1ABC, 0);
    check_xfer("after_rst", 26'h0247ABC);
    b = busy1_c; d = done1_c; h = hi1_c; r = rises1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 500 && done1_c == d; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("div1_busy_cycles", busy1_c - b, BUSY1);
    chk("div1_clk_high", hi1_c - h, 13);
    chk("div1_clk_rises", rises1 - r, 13);
    chk("div1_chain", int'(chain1), 'h1FFF);
    chk("div1_done", done1_c - d, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
